// File: rtl/harry_motion.sv
// harry_motion
// Runner character motion and sprite ROM addressing. A physics state machine
// advances on an internal tick (every 2^TICK_DIV clocks). It handles run, duck,
// multi-jump, float and dead, and drives the sprite top row. The VGA-side logic
// turns the scan position into a sprite ROM address. The frame select is
// registered so that it lines up with a one-cycle synchronous ROM.
//
// Ports
//   clk      : system clock
//   rst      : synchronous reset, active low
//   over     : game over, forces DEAD on the next clock
//   cheat    : float mode request
//   key      : 01 jump, 10 duck, anything else idle
//   row/col  : current VGA scan position
//   pos      : sprite top row (standing frame)
//   state    : 0 RUN, 1 DUCK, 2 JUMP, 3 FLOAT, 4 DEAD
//   jumping  : high while in JUMP
//   landed   : one-clock pulse on the tick a jump touches ground
//   spr_addr : ROM address for the current pixel, 0 outside the sprite
//   spr_sel  : frame select, one clock late: 0 none, 1 jump, 2 dead,
//              3/4 walk A/B, 5/6 duck A/B
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | on the ground, walking animation
// DUCK  | on the ground, crouched sprite
// JUMP  | airborne under gravity (also the free fall after FLOAT)
// FLOAT | pinned at FLOAT_ROW while cheat is held
// DEAD  | motion frozen, left only through reset
module harry_motion #(
   parameter int ROW_W     = 9,
   parameter int COL_W     = 10,
   parameter int STAND_W   = 44,
   parameter int STAND_H   = 47,
   parameter int DUCK_W    = 59,
   parameter int DUCK_H    = 30,
   parameter int SPR_COL   = 50,
   parameter int GROUND    = 300,
   parameter int FLOAT_ROW = 100,
   parameter int V_W       = 6,
   parameter int INIT_V    = 15,
   parameter int GRAVITY   = 1,
   parameter int MAX_JUMPS = 2,
   parameter int TICK_DIV  = 19,
   parameter int ANIM_DIV  = 6,
   parameter int ADDR_W    = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              over,
   input  logic              cheat,
   input  logic [1:0]        key,
   input  logic [ROW_W-1:0]  row,
   input  logic [COL_W-1:0]  col,
   output logic [ROW_W-1:0]  pos,
   output logic [2:0]        state,
   output logic              jumping,
   output logic              landed,
   output logic [ADDR_W-1:0] spr_addr,
   output logic [2:0]        spr_sel
);

   localparam logic [2:0] ST_RUN   = 3'd0;
   localparam logic [2:0] ST_DUCK  = 3'd1;
   localparam logic [2:0] ST_JUMP  = 3'd2;
   localparam logic [2:0] ST_FLOAT = 3'd3;
   localparam logic [2:0] ST_DEAD  = 3'd4;

   localparam int JCNT_W   = $clog2(MAX_JUMPS + 1);
   localparam int ANIM_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam int DUCK_TOP = GROUND + STAND_H - DUCK_H;

   localparam logic [JCNT_W-1:0]     JUMPS_MAX = JCNT_W'(MAX_JUMPS);
   localparam logic [ANIM_W-1:0]     ANIM_LAST = ANIM_W'(ANIM_DIV - 1);
   localparam logic signed [V_W-1:0] V_LAUNCH  = V_W'(-INIT_V);
   localparam logic signed [V_W-1:0] V_MAX     = V_W'(2 ** (V_W - 1) - 1);
   localparam logic signed [V_W:0]   V_MAX_X   = (V_W + 1)'(2 ** (V_W - 1) - 1);
   localparam logic signed [ROW_W+1:0] GROUND_S = (ROW_W + 2)'(GROUND);

   logic [TICK_DIV-1:0]     tick_cnt;
   logic [ANIM_W-1:0]       anim_cnt;
   logic [JCNT_W-1:0]       jumps_used;
   logic signed [V_W-1:0]   vel;
   logic                    frame;
   logic                    key_prev;

   logic                    tick;
   logic                    jump_key;
   logic                    duck_key;
   logic                    jump_edge;
   logic                    on_ground;
   logic                    falling;
   logic signed [ROW_W+1:0] pos_ext;
   logic signed [ROW_W+1:0] vel_ext;
   logic signed [ROW_W+1:0] next_pos;
   logic signed [V_W:0]     vel_inc;
   logic signed [V_W-1:0]   vel_grav;

   logic [31:0]             top_row;
   logic [31:0]             reg_h;
   logic [31:0]             reg_w;
   logic [31:0]             row_x;
   logic [31:0]             col_x;
   logic                    in_region;
   logic [2:0]              sel_nxt;

   assign tick      = &tick_cnt;
   assign jump_key  = (key == 2'b01);
   assign duck_key  = (key == 2'b10);
   // key_prev only moves on a tick, so a held key never looks like a new press
   assign jump_edge = jump_key && !key_prev;
   assign on_ground = (state == ST_RUN) || (state == ST_DUCK);
   assign jumping   = (state == ST_JUMP);

   // Two spare bits keep pos + v from wrapping in either direction
   assign pos_ext  = $signed({2'b00, pos});
   assign vel_ext  = {{(ROW_W + 2 - V_W){vel[V_W-1]}}, vel};
   assign next_pos = pos_ext + vel_ext;
   assign falling  = !vel[V_W-1] && (vel != '0);

   assign vel_inc  = {vel[V_W-1], vel} + (V_W + 1)'(GRAVITY);
   assign vel_grav = (vel_inc > V_MAX_X) ? V_MAX : vel_inc[V_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_RUN;
         pos        <= ROW_W'(GROUND);
         vel        <= '0;
         jumps_used <= '0;
         tick_cnt   <= '0;
         anim_cnt   <= '0;
         frame      <= 1'b0;
         landed     <= 1'b0;
         spr_sel    <= 3'd0;
         key_prev   <= 1'b0;
      end else begin
         tick_cnt <= tick_cnt + TICK_DIV'(1);
         landed   <= 1'b0;
         spr_sel  <= sel_nxt;
         if (state != ST_DEAD) begin
            if (over) begin
               state <= ST_DEAD;
            end else if (tick) begin
               key_prev <= jump_key;
               if (on_ground) begin
                  if (anim_cnt == ANIM_LAST) begin
                     anim_cnt <= '0;
                     frame    <= ~frame;
                  end else begin
                     anim_cnt <= anim_cnt + ANIM_W'(1);
                  end
               end
               if (cheat) begin
                  state <= ST_FLOAT;
                  pos   <= ROW_W'(FLOAT_ROW);
                  vel   <= '0;
               end else if (state == ST_FLOAT) begin
                  // dropping out of float is a free fall with no air jumps left
                  state      <= ST_JUMP;
                  vel        <= '0;
                  jumps_used <= JUMPS_MAX;
               end else if (jump_edge && (jumps_used < JUMPS_MAX)) begin
                  state      <= ST_JUMP;
                  vel        <= V_LAUNCH;
                  jumps_used <= jumps_used + JCNT_W'(1);
               end else if (state == ST_JUMP) begin
                  if (falling && (next_pos >= GROUND_S)) begin
                     pos        <= ROW_W'(GROUND);
                     vel        <= '0;
                     jumps_used <= '0;
                     landed     <= 1'b1;
                     state      <= duck_key ? ST_DUCK : ST_RUN;
                  end else begin
                     pos <= next_pos[ROW_W+1] ? '0 : next_pos[ROW_W-1:0];
                     vel <= vel_grav;
                  end
               end else begin
                  state <= duck_key ? ST_DUCK : ST_RUN;
               end
            end
         end
      end
   end

   // Sprite window: ducking sits on the ground with its own box; every other
   // state uses the standing box hung from pos.
   always_comb begin
      row_x = 32'(row);
      col_x = 32'(col);
      if (state == ST_DUCK) begin
         top_row = 32'(DUCK_TOP);
         reg_h   = 32'(DUCK_H);
         reg_w   = 32'(DUCK_W);
      end else begin
         top_row = 32'(pos);
         reg_h   = 32'(STAND_H);
         reg_w   = 32'(STAND_W);
      end
      in_region = (row_x >= top_row) && (row_x < top_row + reg_h) &&
                  (col_x >= 32'(SPR_COL)) && (col_x < 32'(SPR_COL) + reg_w);
      spr_addr = '0;
      if (in_region) begin
         spr_addr = ADDR_W'((row_x - top_row) * reg_w + (col_x - 32'(SPR_COL)));
      end
      sel_nxt = 3'd0;
      if (in_region) begin
         case (state)
            ST_RUN:   sel_nxt = frame ? 3'd4 : 3'd3;
            ST_DUCK:  sel_nxt = frame ? 3'd6 : 3'd5;
            ST_DEAD:  sel_nxt = 3'd2;
            default:  sel_nxt = 3'd1;
         endcase
      end
   end

endmodule

// File: tb/tb_harry_motion.sv
module tb_harry_motion;

   localparam int ROW_W     = 9;
   localparam int COL_W     = 10;
   localparam int ADDR_W    = 12;
   localparam int TICK_DIV  = 2;
   localparam int GROUND    = 300;
   localparam int FLOAT_ROW = 100;
   localparam int STAND_W   = 44;
   localparam int STAND_H   = 47;
   localparam int DUCK_W    = 59;
   localparam int DUCK_H    = 30;
   localparam int SPR_COL   = 50;
   localparam int INIT_V    = 15;
   localparam int MAX_JUMPS = 2;
   localparam int ANIM_DIV  = 6;
   localparam int V_TOP     = 31;

   localparam int S_RUN = 0, S_DUCK = 1, S_JUMP = 2, S_FLOAT = 3, S_DEAD = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              over = 1'b0;
   logic              cheat = 1'b0;
   logic [1:0]        key = 2'b00;
   logic [ROW_W-1:0]  row = '0;
   logic [COL_W-1:0]  col = '0;
   logic [ROW_W-1:0]  pos;
   logic [2:0]        state;
   logic              jumping;
   logic              landed;
   logic [ADDR_W-1:0] spr_addr;
   logic [2:0]        spr_sel;

   harry_motion #(.TICK_DIV(TICK_DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .over     (over),
      .cheat    (cheat),
      .key      (key),
      .row      (row),
      .col      (col),
      .pos      (pos),
      .state    (state),
      .jumping  (jumping),
      .landed   (landed),
      .spr_addr (spr_addr),
      .spr_sel  (spr_sel)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // reference model: plain integers, one call per clock edge
   int m_st, m_pos, m_v, m_jumps, m_prev, m_anim, m_frame, m_landed, m_sel, m_tcnt;

   bit fix_rc  = 1'b0;
   int fix_row = 0;
   int fix_col = 0;
   int trk_min = 999;
   int trk_land = 0;

   task automatic model_reset();
      m_st = S_RUN; m_pos = GROUND; m_v = 0; m_jumps = 0; m_prev = 0;
      m_anim = 0; m_frame = 0; m_landed = 0; m_sel = 0; m_tcnt = 0;
   endtask

   function automatic int m_top();
      return (m_st == S_DUCK) ? GROUND + STAND_H - DUCK_H : m_pos;
   endfunction

   function automatic int m_wid();
      return (m_st == S_DUCK) ? DUCK_W : STAND_W;
   endfunction

   function automatic bit m_in(input int r, input int c);
      int h;
      h = (m_st == S_DUCK) ? DUCK_H : STAND_H;
      return (r >= m_top()) && (r < m_top() + h) && (c >= SPR_COL) && (c < SPR_COL + m_wid());
   endfunction

   function automatic int m_addr(input int r, input int c);
      if (!m_in(r, c)) return 0;
      return ((r - m_top()) * m_wid() + (c - SPR_COL)) % (1 << ADDR_W);
   endfunction

   function automatic int m_face();
      case (m_st)
         S_RUN:   return 3 + m_frame;
         S_DUCK:  return 5 + m_frame;
         S_DEAD:  return 2;
         default: return 1;
      endcase
   endfunction

   task automatic model_step();
      bit tick, jedge;
      int nxt, sel_n, r, c;
      r = int'(row);
      c = int'(col);
      sel_n = m_in(r, c) ? m_face() : 0;
      if (!rst) begin
         model_reset();
         return;
      end
      tick = (m_tcnt == (1 << TICK_DIV) - 1);
      m_tcnt = (m_tcnt + 1) % (1 << TICK_DIV);
      m_landed = 0;
      m_sel = sel_n;
      if (m_st == S_DEAD) return;
      if (over) begin
         m_st = S_DEAD;
         return;
      end
      if (!tick) return;
      jedge = (key == 2'b01) && (m_prev == 0);
      m_prev = (key == 2'b01) ? 1 : 0;
      if (m_st == S_RUN || m_st == S_DUCK) begin
         m_anim++;
         if (m_anim == ANIM_DIV) begin
            m_anim = 0;
            m_frame = 1 - m_frame;
         end
      end
      if (cheat) begin
         m_st = S_FLOAT; m_pos = FLOAT_ROW; m_v = 0;
      end else if (m_st == S_FLOAT) begin
         m_st = S_JUMP; m_v = 0; m_jumps = MAX_JUMPS;
      end else if (jedge && m_jumps < MAX_JUMPS) begin
         m_st = S_JUMP; m_v = -INIT_V; m_jumps++;
      end else if (m_st == S_JUMP) begin
         nxt = m_pos + m_v;
         if (m_v > 0 && nxt >= GROUND) begin
            m_pos = GROUND; m_v = 0; m_jumps = 0; m_landed = 1;
            m_st = (key == 2'b10) ? S_DUCK : S_RUN;
         end else begin
            m_pos = (nxt < 0) ? 0 : nxt;
            m_v = (m_v + 1 > V_TOP) ? V_TOP : m_v + 1;
         end
      end else begin
         m_st = (key == 2'b10) ? S_DUCK : S_RUN;
      end
   endtask

   task automatic pick_pixel();
      int r;
      if (fix_rc) begin
         row = ROW_W'(fix_row);
         col = COL_W'(fix_col);
      end else begin
         if ($urandom_range(0, 4) == 0) r = int'($urandom_range(0, 511));
         else r = m_top() - 4 + int'($urandom_range(0, STAND_H + 8));
         if (r < 0) r = 0;
         if (r > 511) r = 511;
         row = ROW_W'(r);
         col = COL_W'($urandom_range(SPR_COL - 4, SPR_COL + DUCK_W + 4));
      end
   endtask

   task automatic check_outputs();
      int r, c;
      r = int'(row);
      c = int'(col);
      chk("state", int'(state), m_st);
      chk("pos", int'(pos), m_pos);
      chk("jumping", int'(jumping), (m_st == S_JUMP) ? 1 : 0);
      chk("landed", int'(landed), m_landed);
      chk("spr_sel", int'(spr_sel), m_sel);
      chk("spr_addr", int'(spr_addr), m_addr(r, c));
   endtask

   task automatic run(input logic [1:0] k, input bit ov, input bit ch, input bit rb, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         key = k; over = ov; cheat = ch; rst = rb;
         pick_pixel();
         #1;
         if (bad < 40) check_outputs();
         if (landed) trk_land++;
         if (jumping && int'(pos) < trk_min) trk_min = int'(pos);
         model_step();
      end
   endtask

   initial begin
      int w, n;
      logic [1:0] k;
      bit ch, ov;

      model_reset();
      run(2'b00, 0, 0, 0, 3);
      chk("rst_state", int'(state), S_RUN);
      chk("rst_pos", int'(pos), GROUND);
      chk("rst_sel", int'(spr_sel), 0);
      chk("rst_landed", int'(landed), 0);

      // idle running, animation frames
      run(2'b00, 0, 0, 1, 60);

      // single jump: apex and one landing
      trk_min = 999; trk_land = 0;
      run(2'b01, 0, 0, 1, 4);
      run(2'b00, 0, 0, 1, 150);
      chk("single_apex", trk_min, 180);
      chk("single_lands", trk_land, 1);
      chk("single_end_state", int'(state), S_RUN);

      // double jump, third press ignored
      trk_land = 0;
      run(2'b01, 0, 0, 1, 4);
      run(2'b00, 0, 0, 1, 16);
      run(2'b01, 0, 0, 1, 4);
      run(2'b00, 0, 0, 1, 8);
      run(2'b01, 0, 0, 1, 4);
      run(2'b00, 0, 0, 1, 250);
      chk("double_lands", trk_land, 1);
      chk("double_end_pos", int'(pos), GROUND);

      // held key: one jump only
      trk_land = 0;
      run(2'b01, 0, 0, 1, 200);
      chk("hold_lands", trk_land, 1);
      chk("hold_end_state", int'(state), S_RUN);
      run(2'b00, 0, 0, 1, 8);
      trk_land = 0;
      run(2'b01, 0, 0, 1, 4);
      run(2'b00, 0, 0, 1, 150);
      chk("repress_lands", trk_land, 1);

      // game over mid-jump
      run(2'b01, 0, 0, 1, 4);
      run(2'b00, 0, 0, 1, 20);
      run(2'b00, 1, 0, 1, 1);
      fix_rc = 1'b1; fix_row = m_pos + 3; fix_col = SPR_COL + 5;
      run(2'b01, 0, 1, 1, 20);
      chk("dead_state", int'(state), S_DEAD);
      chk("dead_sel", int'(spr_sel), 2);
      fix_rc = 1'b0;
      run(2'b00, 0, 0, 0, 2);
      chk("rst2_state", int'(state), S_RUN);
      chk("rst2_pos", int'(pos), GROUND);

      // float and free fall
      fix_rc = 1'b1; fix_row = FLOAT_ROW + 10; fix_col = SPR_COL + 10;
      run(2'b00, 0, 1, 1, 12);
      chk("float_pos", int'(pos), FLOAT_ROW);
      chk("float_state", int'(state), S_FLOAT);
      chk("float_sel", int'(spr_sel), 1);
      fix_rc = 1'b0;
      run(2'b00, 0, 0, 1, 250);
      chk("fall_pos", int'(pos), GROUND);
      chk("fall_state", int'(state), S_RUN);

      // duck at the top-left pixel of the duck box
      fix_rc = 1'b1; fix_row = GROUND + STAND_H - DUCK_H; fix_col = SPR_COL;
      run(2'b10, 0, 0, 1, 12);
      chk("duck_state", int'(state), S_DUCK);
      chk("duck_addr", int'(spr_addr), 0);
      chk("duck_sel_ok", (spr_sel == 3'd5 || spr_sel == 3'd6) ? 1 : 0, 1);
      fix_rc = 1'b0;

      // randomized segments
      for (int s = 0; s < 250; s++) begin
         w  = int'($urandom_range(0, 9));
         k  = (w < 4) ? 2'b00 : (w < 7) ? 2'b01 : (w < 9) ? 2'b10 : 2'b11;
         ch = ($urandom_range(0, 14) == 0);
         ov = ($urandom_range(0, 39) == 0);
         n  = int'($urandom_range(1, 24));
         run(k, ov, ch, 1, n);
         if (ov) run(k, 0, 0, 0, 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
